// File: rtl/serial_word_receiver.sv
// ============================================================================
//  Module   : serial_word_receiver
//  Function : Reassembles LSB-first 10-bit serial frames, flags framing errors
//             and pulses o_match when a word equals MATCH_WORD.
//             Define MATCH_COUNT_EN to add the saturating o_match_cnt output.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module serial_word_receiver #(
    parameter int                WIDTH      = 10,
    parameter logic [WIDTH-1:0]  MATCH_WORD = WIDTH'(311)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_seq_bit,
    input  logic             i_tx_done,
    output logic [WIDTH-1:0] o_word,
    output logic             o_word_valid,
    output logic             o_match,
    output logic             o_frame_err,
`ifdef MATCH_COUNT_EN
    output logic [7:0]       o_match_cnt,
`endif
    output logic             o_busy
);

    localparam logic [3:0] c_LAST_BIT = 4'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q,   state_d;
    logic [WIDTH-1:0]   shreg_q,   shreg_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]   word_q,    word_d;
    logic               valid_q,   valid_d;
    logic               match_q,   match_d;
    logic               err_q,     err_d;
    logic               busy_q,    busy_d;

    logic [WIDTH-1:0]   w_shifted;

    assign w_shifted = {i_seq_bit, shreg_q[WIDTH-1:1]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            match_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            match_q   <= match_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    // Word/flag results are registered on the bit-9 edge, so they become
    // visible during the one-cycle DONE state.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        word_d    = word_q;
        valid_d   = 1'b0;
        match_d   = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            ST_RECV: begin
                shreg_d = w_shifted;
                if (i_start) begin
                    err_d     = 1'b1;
                    bit_cnt_d = 4'd1;
                end else if (bit_cnt_q == c_LAST_BIT) begin
                    bit_cnt_d = '0;
                    if (i_tx_done) begin
                        state_d = ST_DONE;
                        word_d  = w_shifted;
                        valid_d = 1'b1;
                        match_d = (w_shifted == MATCH_WORD);
                    end else begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end
                end else if (i_tx_done) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    err_d     = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end

            // DONE accepts a new frame exactly like IDLE.
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
                if (i_start && i_tx_done) begin
                    err_d = 1'b1;
                end else if (i_start) begin
                    shreg_d   = w_shifted;
                    bit_cnt_d = 4'd1;
                    state_d   = ST_RECV;
                end else if (i_tx_done) begin
                    err_d = 1'b1;
                end
            end
        endcase

        busy_d = (state_d == ST_RECV);
    end

    assign o_word       = word_q;
    assign o_word_valid = valid_q;
    assign o_match      = match_q;
    assign o_frame_err  = err_q;
    assign o_busy       = busy_q;

`ifdef MATCH_COUNT_EN
    logic [7:0] match_cnt_q, match_cnt_d;

    always_comb begin
        match_cnt_d = match_cnt_q;
        if (match_q && (match_cnt_q != 8'hFF)) begin
            match_cnt_d = match_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            match_cnt_q <= '0;
        end else begin
            match_cnt_q <= match_cnt_d;
        end
    end

    assign o_match_cnt = match_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_word_receiver.sv
// ============================================================================
//  Module   : tb_serial_word_receiver
//  Function : Scoreboard-based self-checking bench for serial_word_receiver.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_serial_word_receiver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       i_start = 1'b0;
    logic       i_seq_bit = 1'b0;
    logic       i_tx_done = 1'b0;
    logic [9:0] o_word;
    logic       o_word_valid;
    logic       o_match;
    logic       o_frame_err;
    logic       o_busy;
`ifdef MATCH_COUNT_EN
    logic [7:0] o_match_cnt;
`endif

    typedef struct {
        logic [9:0] word;
        logic       match;
    } exp_t;

    exp_t exp_q[$];
    int   valid_cyc_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   err_seen = 0;
    int   cyc      = 0;

    serial_word_receiver dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (i_start),
        .i_seq_bit    (i_seq_bit),
        .i_tx_done    (i_tx_done),
        .o_word       (o_word),
        .o_word_valid (o_word_valid),
        .o_match      (o_match),
        .o_frame_err  (o_frame_err),
`ifdef MATCH_COUNT_EN
        .o_match_cnt  (o_match_cnt),
`endif
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor
    always @(negedge clk) begin
        if (o_frame_err) err_seen = err_seen + 1;
        if (o_word_valid || o_frame_err) begin
            n_checks = n_checks + 1;
            if (o_word_valid && o_frame_err) begin
                n_fail = n_fail + 1;
                $display("FAIL valid_err_overlap: valid=%b err=%b required not both", o_word_valid, o_frame_err);
            end
        end
        if (o_word_valid) begin
            valid_cyc_q.push_back(cyc);
            n_checks = n_checks + 1;
            if (exp_q.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL sb_unexpected_word: got word=%0d, required no valid pulse", o_word);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (o_word !== e.word) begin
                    n_fail = n_fail + 1;
                    $display("FAIL sb_word: got %0d required %0d", o_word, e.word);
                end
                n_checks = n_checks + 1;
                if (o_match !== e.match) begin
                    n_fail = n_fail + 1;
                    $display("FAIL sb_match: got %b required %b (word %0d)", o_match, e.match, e.word);
                end
            end
        end else if (o_match) begin
            n_checks = n_checks + 1;
            n_fail = n_fail + 1;
            $display("FAIL match_without_valid: match=%b required 0", o_match);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic s, input logic b, input logic d);
        i_start   = s;
        i_seq_bit = b;
        i_tx_done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic push_exp(input logic [9:0] w);
        exp_t e;
        e.word  = w;
        e.match = (w == 10'd311);
        exp_q.push_back(e);
    endtask

    task automatic send_frame(input logic [9:0] w);
        push_exp(w);
        for (int i = 0; i < 10; i++) drive(i == 0, w[i], i == 9);
    endtask

    task automatic check_err_delta(input string name, input int base, input int delta);
        n_checks++;
        if (err_seen !== base + delta) begin
            n_fail++;
            $display("FAIL %s: frame_err pulses got %0d required %0d", name, err_seen - base, delta);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o_word, o_word_valid, o_match, o_frame_err, o_busy} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got word=%0d v=%b m=%b e=%b b=%b required all 0",
                     o_word, o_word_valid, o_match, o_frame_err, o_busy);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);
        n_checks++;
        if ({o_word, o_word_valid, o_match, o_frame_err, o_busy} !== 14'd0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got word=%0d v=%b m=%b e=%b b=%b required all 0",
                     o_word, o_word_valid, o_match, o_frame_err, o_busy);
        end
    endtask

    task automatic test_match_frame();
        logic [9:0] w;
        w = 10'd311;
        push_exp(w);
        for (int i = 0; i < 10; i++) begin
            drive(i == 0, w[i], i == 9);
            n_checks++;
            if (i < 9) begin
                if (o_busy !== 1'b1 || o_word_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL busy_cycle%0d: busy=%b valid=%b required busy=1 valid=0", i + 1, o_busy, o_word_valid);
                end
            end else begin
                if (o_busy !== 1'b0 || o_word_valid !== 1'b1 || o_match !== 1'b1 || o_word !== 10'd311) begin
                    n_fail++;
                    $display("FAIL latency_cycle10: busy=%b valid=%b match=%b word=%0d required 0,1,1,311",
                             o_busy, o_word_valid, o_match, o_word);
                end
            end
        end
        idle(1);
        n_checks++;
        if (o_word_valid !== 1'b0 || o_word !== 10'd311) begin
            n_fail++;
            $display("FAIL valid_one_cycle: valid=%b word=%0d required 0, 311", o_word_valid, o_word);
        end
    endtask

    task automatic test_nonmatch();
        int e0;
        e0 = err_seen;
        send_frame(10'h2AA);
        idle(3);
        check_err_delta("nonmatch_no_err", e0, 0);
    endtask

    task automatic test_back_to_back();
        int e0, n0, t0, t1;
        e0 = err_seen;
        n0 = valid_cyc_q.size();
        send_frame(10'd311);
        send_frame(10'h155);
        idle(3);
        check_err_delta("b2b_no_err", e0, 0);
        n_checks++;
        if (valid_cyc_q.size() !== n0 + 2) begin
            n_fail++;
            $display("FAIL b2b_pulses: got %0d valid pulses required 2", valid_cyc_q.size() - n0);
        end else begin
            t0 = valid_cyc_q[n0];
            t1 = valid_cyc_q[n0 + 1];
            n_checks++;
            if (t1 - t0 !== 10) begin
                n_fail++;
                $display("FAIL b2b_spacing: got %0d cycles required 10", t1 - t0);
            end
        end
    endtask

    task automatic test_early_done();
        int e0;
        logic [9:0] w;
        w = 10'h3C3;
        e0 = err_seen;
        for (int i = 0; i < 7; i++) drive(i == 0, w[i], i == 6);
        n_checks++;
        if (o_frame_err !== 1'b1 || o_word_valid !== 1'b0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL early_done: err=%b valid=%b busy=%b required 1,0,0", o_frame_err, o_word_valid, o_busy);
        end
        idle(3);
        n_checks++;
        if (o_word !== 10'h155) begin
            n_fail++;
            $display("FAIL early_done_hold: word=%0d required %0d", o_word, 10'h155);
        end
        check_err_delta("early_done_errs", e0, 1);
        send_frame(10'h0F0);
        idle(2);
    endtask

    task automatic test_missing_done();
        int e0;
        e0 = err_seen;
        for (int i = 0; i < 10; i++) drive(i == 0, 1'b1, 1'b0);
        n_checks++;
        if (o_frame_err !== 1'b1 || o_word_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL missing_done: err=%b valid=%b required 1,0", o_frame_err, o_word_valid);
        end
        idle(2);
        check_err_delta("missing_done_errs", e0, 1);
    endtask

    task automatic test_idle_errors();
        int e0;
        e0 = err_seen;
        drive(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (o_frame_err !== 1'b1 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_done_err: err=%b busy=%b required 1,0", o_frame_err, o_busy);
        end
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        n_checks++;
        if (o_frame_err !== 1'b1 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_start_done_err: err=%b busy=%b required 1,0", o_frame_err, o_busy);
        end
        idle(2);
        check_err_delta("idle_errs", e0, 2);
    endtask

    task automatic test_restart();
        int e0;
        e0 = err_seen;
        for (int i = 0; i < 4; i++) drive(i == 0, 1'b1, 1'b0);
        send_frame(10'd311);
        idle(2);
        check_err_delta("restart_errs", e0, 1);
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] w;
        w = 10'd311;
        for (int i = 0; i < 6; i++) drive(i == 0, w[i], 1'b0);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o_word, o_word_valid, o_match, o_frame_err, o_busy} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_mid_frame: word=%0d v=%b m=%b e=%b b=%b required all 0",
                     o_word, o_word_valid, o_match, o_frame_err, o_busy);
        end
        i_start = 1'b0; i_tx_done = 1'b0; i_seq_bit = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);
        send_frame(10'd311);
        idle(3);
`ifdef MATCH_COUNT_EN
        n_checks++;
        if (o_match_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL match_cnt_after_reset: got %0d required 1", o_match_cnt);
        end
`endif
    endtask

`ifdef MATCH_COUNT_EN
    task automatic test_match_saturate();
        for (int k = 0; k < 257; k++) send_frame(10'd311);
        idle(3);
        n_checks++;
        if (o_match_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL match_cnt_saturate: got %0d required 255", o_match_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_match_frame();
        test_nonmatch();
        test_back_to_back();
        test_early_done();
        test_missing_done();
        test_idle_errors();
        test_restart();
        test_reset_mid_frame();
`ifdef MATCH_COUNT_EN
        test_match_saturate();
`endif
        idle(2);
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d expected words never produced, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
